// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction issuer: field layout, opcodes,
// FSM state encoding and small decode helpers used by issuer and hazard checker.
package isa_pkg;

  localparam int INS_W    = 16;
  localparam int REG_W    = 3;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 9;
  localparam int DEST_MSB = 8;
  localparam int DEST_LSB = 6;
  localparam int SRCB_MSB = 5;
  localparam int SRCB_LSB = 3;
  localparam int SRCA_MSB = 2;
  localparam int SRCA_LSB = 0;

  localparam logic [6:0] OP_NOP  = 7'd0;
  localparam logic [6:0] OP_LOAD = 7'd1;
  localparam logic [6:0] OP_ADD  = 7'd2;

  localparam logic [INS_W-1:0] NOP_WORD = 16'h0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  typedef struct packed {
    logic [6:0]       op;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src_b;
    logic [REG_W-1:0] src_a;
  } ins_t;

  function automatic logic writes_reg(input logic [INS_W-1:0] w);
    return (w[OP_MSB:OP_LSB] == OP_LOAD) || (w[OP_MSB:OP_LSB] == OP_ADD);
  endfunction

  // LOAD addresses through srcB only; NOP reads nothing; every other op reads both.
  function automatic logic reads_a(input logic [INS_W-1:0] w);
    return (w[OP_MSB:OP_LSB] != OP_NOP) && (w[OP_MSB:OP_LSB] != OP_LOAD);
  endfunction

  function automatic logic reads_b(input logic [INS_W-1:0] w);
    return (w[OP_MSB:OP_LSB] != OP_NOP);
  endfunction

endpackage

// File: rtl/raw_hazard_chk.sv
// Combinational read-after-write check of a candidate instruction against the
// two most recently issued destination slots (slot 0 = newest).
module raw_hazard_chk
  import isa_pkg::*;
(
  input  logic [INS_W-1:0] i_cand,
  input  logic             i_slot0_valid,
  input  logic [REG_W-1:0] i_slot0_dest,
  input  logic             i_slot1_valid,
  input  logic [REG_W-1:0] i_slot1_dest,
  output logic             o_hazard
);

  logic             w_rd_a;
  logic             w_rd_b;
  logic [REG_W-1:0] w_src_a;
  logic [REG_W-1:0] w_src_b;
  logic [1:0]       w_slot_valid;
  logic [1:0][REG_W-1:0] w_slot_dest;
  logic [1:0]       w_hit;
  logic             w_unused_dest;

  assign w_rd_a        = reads_a(i_cand);
  assign w_rd_b        = reads_b(i_cand);
  assign w_src_a       = i_cand[SRCA_MSB:SRCA_LSB];
  assign w_src_b       = i_cand[SRCB_MSB:SRCB_LSB];
  assign w_unused_dest = ^i_cand[DEST_MSB:DEST_LSB];

  assign w_slot_valid = {i_slot1_valid, i_slot0_valid};
  assign w_slot_dest  = {i_slot1_dest, i_slot0_dest};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign w_hit[gi] = w_slot_valid[gi] &&
                         ((w_rd_a && (w_src_a == w_slot_dest[gi])) ||
                          (w_rd_b && (w_src_b == w_slot_dest[gi])));
    end
  endgenerate

  assign o_hazard = |w_hit;

endmodule

// File: rtl/ins_issuer.sv
// In-order instruction issuer: loads a small program, then issues it with
// RAW-hazard bubbles, drains two NOPs and pulses done.
module ins_issuer
  import isa_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_adr,
  input  logic [INS_W-1:0] prog_data,
  input  logic             start,
  input  logic [AW:0]      prog_len,
  output logic [INS_W-1:0] ins,
  output logic             ins_valid,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             done,
  output logic [7:0]       bubble_cnt
);

  logic [INS_W-1:0] r_mem [PROG_DEPTH];
  logic [1:0]       r_state;
  logic [AW:0]      r_len;
  logic [AW-1:0]    r_pc;
  logic [INS_W-1:0] r_ins;
  logic             r_ins_valid;
  logic             r_done;
  logic [7:0]       r_bubble;
  logic             r_drain_last;
  logic [1:0]       r_slot_v;
  logic [1:0][REG_W-1:0] r_slot_d;

  logic             w_idle;
  logic [AW-1:0]    w_rd_adr;
  logic [INS_W-1:0] w_cand;
  logic             w_hazard;
  logic             w_new_v;
  logic [REG_W-1:0] w_new_d;
  logic             w_last;

  assign w_idle   = (r_state == ST_IDLE);
  // The first instruction is issued on the start edge itself, so IDLE reads index 0.
  assign w_rd_adr = w_idle ? '0 : r_pc;
  // A write to index 0 coinciding with start must be seen by that first issue.
  assign w_cand   = (w_idle && prog_we && (prog_adr == '0)) ? prog_data : r_mem[w_rd_adr];
  assign w_new_v  = writes_reg(w_cand);
  assign w_new_d  = w_cand[DEST_MSB:DEST_LSB];
  assign w_last   = (({1'b0, r_pc} + (AW+1)'(1)) == r_len);

  raw_hazard_chk u_hazard (
    .i_cand        (w_cand),
    .i_slot0_valid (r_slot_v[0]),
    .i_slot0_dest  (r_slot_d[0]),
    .i_slot1_valid (r_slot_v[1]),
    .i_slot1_dest  (r_slot_d[1]),
    .o_hazard      (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (w_idle && prog_we) begin
      r_mem[prog_adr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_pc         <= '0;
      r_ins        <= NOP_WORD;
      r_ins_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_bubble     <= '0;
      r_drain_last <= 1'b0;
      r_slot_v     <= '0;
      r_slot_d     <= '0;
    end else begin
      r_ins       <= NOP_WORD;
      r_ins_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len        <= prog_len;
            r_bubble     <= '0;
            r_drain_last <= 1'b0;
            if (prog_len == '0) begin
              r_pc     <= '0;
              r_state  <= ST_DRAIN;
              r_slot_v <= {r_slot_v[0], 1'b0};
              r_slot_d <= {r_slot_d[0], {REG_W{1'b0}}};
            end else begin
              r_ins       <= w_cand;
              r_ins_valid <= 1'b1;
              r_pc        <= AW'(1);
              r_slot_v    <= {r_slot_v[0], w_new_v};
              r_slot_d    <= {r_slot_d[0], w_new_d};
              r_state     <= (prog_len == (AW+1)'(1)) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_hazard) begin
            r_bubble <= (r_bubble == 8'hFF) ? r_bubble : r_bubble + 8'd1;
            r_slot_v <= {r_slot_v[0], 1'b0};
            r_slot_d <= {r_slot_d[0], {REG_W{1'b0}}};
          end else begin
            r_ins       <= w_cand;
            r_ins_valid <= 1'b1;
            r_pc        <= r_pc + AW'(1);
            r_slot_v    <= {r_slot_v[0], w_new_v};
            r_slot_d    <= {r_slot_d[0], w_new_d};
            if (w_last) begin
              r_state      <= ST_DRAIN;
              r_drain_last <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          r_slot_v <= {r_slot_v[0], 1'b0};
          r_slot_d <= {r_slot_d[0], {REG_W{1'b0}}};
          if (r_drain_last) begin
            r_state <= ST_FIN;
            r_done  <= 1'b1;
          end else begin
            r_drain_last <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ins        = r_ins;
  assign ins_valid  = r_ins_valid;
  assign pc         = r_pc;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign bubble_cnt = r_bubble;

endmodule
